// File: rtl/snn_pkg.sv
// Shared definitions for the spike encoder slice.
//   DATA_W_DEF / WIN_W_DEF : default rate width and window/counter width
//   enc_state_t            : encoder FSM states
//   LFSR_*                 : 16-bit Fibonacci LFSR seed and tap mask
package snn_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int WIN_W_DEF  = 16;

    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } enc_state_t;

endpackage

// File: rtl/spike_rate_encoder_if.sv
// Request channel of the spike rate encoder.
//   in_valid   : requester has a (rate, window length) pair
//   in_ready   : encoder can accept this cycle
//   in_rate    : spike probability per cycle = in_rate / 2^DATA_W
//   in_win_len : window length in cycles (0 behaves as 1)
// master = requester side, slave = encoder side.
interface spike_rate_encoder_if #(
    parameter int DATA_W = 8,
    parameter int WIN_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_rate;
    logic [WIN_W-1:0]  in_win_len;

    modport master (
        output in_valid,
        output in_rate,
        output in_win_len,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_rate,
        input  in_win_len,
        output in_ready
    );
endinterface

// File: rtl/spike_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded on synchronous reset.
//   clk : clock
//   rst : synchronous active-high reset, loads LFSR_SEED
//   en  : advance one step
//   q   : current LFSR state
module spike_lfsr
    import snn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    logic fb;

    assign fb = ^(q & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= {q[LFSR_W-2:0], fb};
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes an intensity into a spike train on syn for a fixed window.
//   clk, rst   : clock, synchronous active-high reset
//   req        : request channel (slave side), rate + window length
//   syn        : registered one-cycle spike pulses
//   busy       : a window is in progress
//   done       : pulse on the last cycle of a window
//   spike_cnt  : spikes in the finished window, updated with done, held after
// Build option: SPIKE_ENC_STOCHASTIC_EN selects LFSR comparison encoding
// instead of the deterministic carry accumulator.
//
// state | meaning
// IDLE  | no window active, ready for a request
// RUN   | window active; rem_q counts cycles left including the current one
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WIN_W  = WIN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    spike_rate_encoder_if.slave  req,
    output logic                 syn,
    output logic                 busy,
    output logic                 done,
    output logic [WIN_W-1:0]     spike_cnt
);

    enc_state_t        state_q, state_d;
    logic [WIN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] rate_q, rate_d;
    logic              syn_q, syn_d;
    logic [WIN_W-1:0]  cnt_q, cnt_d;
    logic [WIN_W-1:0]  spike_cnt_q, spike_cnt_d;

    logic              last;
    logic              accept;
    logic              run_on;
    logic              spike;
    logic [DATA_W-1:0] rate_sel;
    logic [WIN_W-1:0]  base_cnt;
    logic [WIN_W:0]    cnt_sum;

`ifdef SPIKE_ENC_STOCHASTIC_EN
    logic [LFSR_W-1:0] lfsr_q;

    spike_lfsr u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (run_on),
        .q   (lfsr_q)
    );
`else
    // acc_q holds the low bits of the sum produced for the current cycle.
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] base_acc;
    logic [DATA_W:0]   acc_sum;
`endif

    assign last        = (state_q == RUN) && (rem_q == WIN_W'(1));
    assign req.in_ready = !rst && ((state_q == IDLE) || last);
    assign accept      = req.in_valid && req.in_ready;
    // True on every edge that enters a RUN cycle (new window or continuation).
    assign run_on      = accept || ((state_q == RUN) && !last);

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        rate_d      = rate_q;
        syn_d       = 1'b0;
        cnt_d       = cnt_q;
        spike_cnt_d = spike_cnt_q;
        rate_sel    = rate_q;
        base_cnt    = cnt_q;
`ifndef SPIKE_ENC_STOCHASTIC_EN
        acc_d       = acc_q;
        base_acc    = acc_q;
`endif

        if (accept) begin
            state_d  = RUN;
            rate_d   = req.in_rate;
            rate_sel = req.in_rate;
            rem_d    = (req.in_win_len == '0) ? WIN_W'(1) : req.in_win_len;
            base_cnt = '0;
`ifndef SPIKE_ENC_STOCHASTIC_EN
            base_acc = '0;
`endif
        end else if (state_q == RUN && !last) begin
            rem_d = rem_q - WIN_W'(1);
        end else if (last) begin
            state_d = IDLE;
            rem_d   = '0;
        end

`ifdef SPIKE_ENC_STOCHASTIC_EN
        spike = (lfsr_q[DATA_W-1:0] < rate_sel);
`else
        acc_sum = {1'b0, base_acc} + {1'b0, rate_sel};
        spike   = acc_sum[DATA_W];
`endif

        cnt_sum = {1'b0, base_cnt} + {{WIN_W{1'b0}}, spike};

        if (run_on) begin
            syn_d = spike;
            cnt_d = cnt_sum[WIN_W] ? '1 : cnt_sum[WIN_W-1:0];
`ifndef SPIKE_ENC_STOCHASTIC_EN
            acc_d = acc_sum[DATA_W-1:0];
`endif
            // Entering the final cycle: publish the count including its spike.
            if (rem_d == WIN_W'(1)) begin
                spike_cnt_d = cnt_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            rate_q      <= '0;
            syn_q       <= 1'b0;
            cnt_q       <= '0;
            spike_cnt_q <= '0;
`ifndef SPIKE_ENC_STOCHASTIC_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            rate_q      <= rate_d;
            syn_q       <= syn_d;
            cnt_q       <= cnt_d;
            spike_cnt_q <= spike_cnt_d;
`ifndef SPIKE_ENC_STOCHASTIC_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign syn       = syn_q;
    assign busy      = (state_q == RUN);
    assign done      = last;
    assign spike_cnt = spike_cnt_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed self-checking bench for spike_rate_encoder.
// Define SPIKE_ENC_STOCHASTIC_EN to exercise the LFSR build.
module tb_spike_rate_encoder;

    logic        clk;
    logic        rst;
    logic        syn;
    logic        busy;
    logic        done;
    logic [15:0] spike_cnt;

    int checks = 0;
    int errors = 0;

    logic        syn_log  [1:300];
    logic        busy_log [1:300];
    logic        done_log [1:300];
    logic [15:0] cnt_log  [1:300];

    spike_rate_encoder_if #(.DATA_W(8), .WIN_W(16)) ifc ();

    spike_rate_encoder #(.DATA_W(8), .WIN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (ifc),
        .syn       (syn),
        .busy      (busy),
        .done      (done),
        .spike_cnt (spike_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    // Drive a request and wait (bounded) for it to be accepted; returns #1 after the accept edge.
    task automatic send_req(input logic [7:0] r, input logic [15:0] l);
        int waited;
        waited = 0;
        @(negedge clk);
        ifc.in_valid   = 1'b1;
        ifc.in_rate    = r;
        ifc.in_win_len = l;
        while (!ifc.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%b required=1", ifc.in_ready);
            ifc.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            ifc.in_valid = 1'b0;
        end
    endtask

    // Log outputs for window cycles 1..n (sampled on the falling edge).
    task automatic record(input int n);
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            syn_log[j]  = syn;
            busy_log[j] = busy;
            done_log[j] = done;
            cnt_log[j]  = spike_cnt;
        end
    endtask

    task automatic test_reset;
        rst            = 1'b1;
        ifc.in_valid   = 1'b0;
        ifc.in_rate    = '0;
        ifc.in_win_len = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({syn, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs syn/busy/done=%b required=000", {syn, busy, done});
        end
        checks++;
        if (spike_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_spike_cnt got=%0d required=0", spike_cnt);
        end
        checks++;
        if (ifc.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got=%b required=0", ifc.in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready got=%b required=1", ifc.in_ready);
        end
    endtask

    task automatic test_basic;
        logic [7:0] sv;
        logic [8:0] bv, dv;
        send_req(8'd128, 16'd8);
        // Mid-window changes must be ignored.
        ifc.in_rate    = 8'd255;
        ifc.in_win_len = 16'd3;
        record(9);
        for (int j = 1; j <= 9; j++) begin
            if (j <= 8) sv[j-1] = syn_log[j];
            bv[j-1] = busy_log[j];
            dv[j-1] = done_log[j];
        end
        checks++;
        if (sv !== 8'hAA) begin
            errors++;
            $display("FAIL basic_syn_pattern got=%b required=%b", sv, 8'hAA);
        end
        checks++;
        if (bv !== 9'h0FF) begin
            errors++;
            $display("FAIL basic_busy got=%b required=%b", bv, 9'h0FF);
        end
        checks++;
        if (dv !== 9'h080) begin
            errors++;
            $display("FAIL basic_done got=%b required=%b", dv, 9'h080);
        end
        checks++;
        if (cnt_log[8] !== 16'd4) begin
            errors++;
            $display("FAIL basic_spike_cnt got=%0d required=4", cnt_log[8]);
        end
        checks++;
        if (cnt_log[9] !== 16'd4) begin
            errors++;
            $display("FAIL basic_spike_cnt_hold got=%0d required=4", cnt_log[9]);
        end
    endtask

    task automatic test_rate_extremes;
        int spikes, dones, first_done;
        send_req(8'd0, 16'd100);
        record(101);
        spikes = 0; dones = 0; first_done = 0;
        for (int j = 1; j <= 101; j++) begin
            if (syn_log[j] === 1'b1) spikes++;
            if (done_log[j] === 1'b1) begin
                dones++;
                if (first_done == 0) first_done = j;
            end
        end
        checks++;
        if (spikes != 0) begin
            errors++;
            $display("FAIL rate0_spikes got=%0d required=0", spikes);
        end
        checks++;
        if (first_done != 100 || dones != 1) begin
            errors++;
            $display("FAIL rate0_done first=%0d count=%0d required first=100 count=1", first_done, dones);
        end
        checks++;
        if (cnt_log[100] !== 16'd0 || busy_log[101] !== 1'b0) begin
            errors++;
            $display("FAIL rate0_end cnt=%0d busy=%b required cnt=0 busy=0", cnt_log[100], busy_log[101]);
        end

        send_req(8'd255, 16'd256);
        record(257);
        spikes = 0;
        for (int j = 1; j <= 257; j++) if (syn_log[j] === 1'b1) spikes++;
        checks++;
        if (spikes != 255) begin
            errors++;
            $display("FAIL rate255_syn_count got=%0d required=255", spikes);
        end
        checks++;
        if (cnt_log[256] !== 16'd255 || done_log[256] !== 1'b1) begin
            errors++;
            $display("FAIL rate255_done cnt=%0d done=%b required cnt=255 done=1", cnt_log[256], done_log[256]);
        end
        checks++;
        if (busy_log[257] !== 1'b0 || done_log[255] !== 1'b0) begin
            errors++;
            $display("FAIL rate255_window_end busy257=%b done255=%b required 0 0", busy_log[257], done_log[255]);
        end
    endtask

    task automatic test_back_to_back;
        int acc_cycle;
        logic [12:0] sv, bv, dv;
        send_req(8'd128, 16'd8);
        ifc.in_valid   = 1'b1;
        ifc.in_rate    = 8'd64;
        ifc.in_win_len = 16'd4;
        acc_cycle = 0;
        for (int j = 1; j <= 13; j++) begin
            @(negedge clk);
            syn_log[j]  = syn;
            busy_log[j] = busy;
            done_log[j] = done;
            cnt_log[j]  = spike_cnt;
            if (ifc.in_valid && ifc.in_ready) begin
                acc_cycle = j;
                @(posedge clk);
                #1;
                ifc.in_valid = 1'b0;
            end
        end
        ifc.in_valid = 1'b0;
        for (int j = 1; j <= 13; j++) begin
            sv[j-1] = syn_log[j];
            bv[j-1] = busy_log[j];
            dv[j-1] = done_log[j];
        end
        checks++;
        if (acc_cycle != 8) begin
            errors++;
            $display("FAIL b2b_accept_cycle got=%0d required=8", acc_cycle);
        end
        checks++;
        if (sv !== 13'h08AA) begin
            errors++;
            $display("FAIL b2b_syn got=%b required=%b", sv, 13'h08AA);
        end
        checks++;
        if (bv !== 13'h0FFF) begin
            errors++;
            $display("FAIL b2b_busy got=%b required=%b", bv, 13'h0FFF);
        end
        checks++;
        if (dv !== 13'h0880) begin
            errors++;
            $display("FAIL b2b_done got=%b required=%b", dv, 13'h0880);
        end
        checks++;
        if (cnt_log[8] !== 16'd4 || cnt_log[12] !== 16'd1) begin
            errors++;
            $display("FAIL b2b_spike_cnt first=%0d second=%0d required 4 1", cnt_log[8], cnt_log[12]);
        end
    endtask

    task automatic test_win_zero;
        send_req(8'd255, 16'd0);
        record(2);
        checks++;
        if (done_log[1] !== 1'b1 || busy_log[1] !== 1'b1 || busy_log[2] !== 1'b0) begin
            errors++;
            $display("FAIL win0_timing done1=%b busy1=%b busy2=%b required 1 1 0", done_log[1], busy_log[1], busy_log[2]);
        end
        checks++;
        if (cnt_log[1] !== 16'd0 || syn_log[1] !== 1'b0) begin
            errors++;
            $display("FAIL win0_count cnt=%0d syn=%b required cnt=0 syn=0", cnt_log[1], syn_log[1]);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        send_req(8'd200, 16'd8);
        record(2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({syn, busy, done} !== 3'b000 || ifc.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort syn/busy/done=%b ready=%b required 000 0", {syn, busy, done}, ifc.in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready got=%b required=1", ifc.in_ready);
        end
        bad = 0;
        for (int j = 0; j < 6; j++) begin
            if (syn !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_quiet activity_cycles=%0d required=0", bad);
        end
        send_req(8'd128, 16'd2);
        record(2);
        checks++;
        if (syn_log[1] !== 1'b0 || syn_log[2] !== 1'b1 || cnt_log[2] !== 16'd1 || done_log[2] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_clean_window syn=%b%b cnt=%0d done=%b required syn=01 cnt=1 done=1",
                     syn_log[1], syn_log[2], cnt_log[2], done_log[2]);
        end
    endtask

`ifdef SPIKE_ENC_STOCHASTIC_EN
    task automatic test_stochastic;
        logic [15:0] s;
        int exp_cnt, mism;
        logic exp_syn;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s = 16'hACE1;
        exp_cnt = 0;
        mism = 0;
        send_req(8'd64, 16'd4096);
        for (int j = 1; j <= 4096; j++) begin
            @(negedge clk);
            exp_syn = (s[7:0] < 8'd64);
            if (syn !== exp_syn) mism++;
            if (exp_syn) exp_cnt++;
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL stoch_sequence mismatched_cycles=%0d required=0", mism);
        end
        checks++;
        if (spike_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL stoch_spike_cnt got=%0d required=%0d", spike_cnt, exp_cnt);
        end
        checks++;
        if (spike_cnt < 16'd928 || spike_cnt > 16'd1120) begin
            errors++;
            $display("FAIL stoch_range got=%0d required 928..1120", spike_cnt);
        end
    endtask
`endif

    initial begin
        rst            = 1'b1;
        ifc.in_valid   = 1'b0;
        ifc.in_rate    = '0;
        ifc.in_win_len = '0;
        test_reset();
`ifdef SPIKE_ENC_STOCHASTIC_EN
        test_stochastic();
`else
        test_basic();
        test_rate_extremes();
        test_back_to_back();
        test_win_zero();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
- Rate-codes an 8-bit intensity into a spike train on `syn`, which drives the synaptic input of a LIF neuron.
- It is the transmitting end of the neuron's `syn` interface, the counterpart to the neuron's `axon` output.
- It accepts one (rate, window length) request over a valid/ready handshake and emits spikes for exactly that many cycles.
- At the end of the window it reports the number of spikes emitted.

Parameters:
- DATA_W, 8: width of the rate value. Full scale is 2^DATA_W.
- WIN_W, 16: width of the window-length input and of the spike counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request this cycle.
- in_rate  input  DATA_W  spike probability per cycle, equal to in_rate/2^DATA_W.
- in_win_len  input  WIN_W  window length in cycles. 0 is treated as 1.
- syn  output  1  registered spike output, one-cycle pulses.
- busy  output  1  a window is in progress.
- done  output  1  one-cycle pulse on the last cycle of a window.
- spike_cnt  output  WIN_W  spikes emitted in the window. Valid when done=1; holds its value until the next done.

Behaviour:
- States: IDLE, RUN.
- Accept occurs when in_valid && in_ready.
  - The encoder latches rate, sets remaining = max(in_win_len,1), clears acc (DATA_W+1 bits) and clears the running count.
  - The encoder then moves to RUN.
- Latency: after an accept at edge k, syn is driven during cycles k+1 .. k+L (L = window length). busy=1 over those same cycles.
- Deterministic encoding, applied each RUN cycle:
  - acc_next = acc[DATA_W-1:0] + rate.
  - syn = acc_next[DATA_W] (the carry).
  - Spikes in a window = floor(L*rate/2^DATA_W).
  - rate=0 never spikes. rate=2^DATA_W-1 spikes on all but one cycle per 2^DATA_W cycles.
- Counting:
  - The running count increments on every syn=1 and saturates at 2^WIN_W-1.
  - On the last RUN cycle (remaining==1), done=1 and spike_cnt = the final count including that cycle's spike.
- in_ready = !rst && (state==IDLE || (state==RUN && remaining==1)).
  - This allows back-to-back windows with no gap cycle. acc and count reset at the new accept.
- Transitions:
  - IDLE to RUN on accept.
  - RUN to IDLE on the last cycle with no accept.
  - RUN to RUN on the last cycle with an accept.
- in_rate and in_win_len are ignored when no accept occurs. Changes to them mid-window have no effect.
- Reset values: state=IDLE, syn=0, busy=0, done=0, spike_cnt=0, acc=0, remaining=0. in_ready=0 while rst=1.
- Reset mid-window aborts immediately: no done pulse and no further spikes. in_ready=1 in the first cycle after rst deasserts.
- An in_valid held while busy (not the last cycle) waits. The request must be held stable until accepted.

Optional Feature:
- Macro: SPIKE_ENC_STOCHASTIC_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) advances every RUN cycle.
  - syn = (lfsr[DATA_W-1:0] < rate). The accumulator is unused.
  - The LFSR is not reseeded per window, so it is only reproducible from reset.
- Undefined: deterministic accumulator encoding as above. No LFSR logic is present.
- Handshake, window timing, done and spike_cnt are identical in both builds.

Decomposition:
- Shared package snn_pkg holds:
  - the DATA_W and WIN_W defaults;
  - the encoder state enum (IDLE, RUN);
  - the LFSR seed and tap constants.
- One sub-module: spike_lfsr, a 16-bit LFSR with enable and synchronous reset. It is instantiated only under SPIKE_ENC_STOCHASTIC_EN.

Test Plan:
- Reset, then rate=128, win_len=8, deterministic build -> syn=1 on window cycles 2,4,6,8 only; done on cycle 8; spike_cnt=4; busy high for 8 cycles.
- rate=0, win_len=100 -> syn never 1; done after 100 cycles; spike_cnt=0. Then rate=255, win_len=256 -> spike_cnt=255.
- Back-to-back: second request (rate=64, len=4) held valid during first window (rate=128, len=8) -> accepted on the first window's last cycle; no gap cycle; second window emits 1 spike, on its 4th cycle; two done pulses 4 cycles apart.
- win_len=0, rate=255 -> treated as a 1-cycle window: done one cycle after accept; spike_cnt=0 (acc carry does not occur on the first cycle).
- rst asserted on cycle 3 of an 8-cycle window -> syn/busy/done=0 next cycle; no done pulse; in_ready=1 the cycle after rst deasserts; new request runs from a clean acc.
- SPIKE_ENC_STOCHASTIC_EN build: rate=64, win_len=4096 -> spike_cnt within 1024±96; LFSR sequence matches the reference model from seed 16'hACE1.
